irq_sequencer: RTL and testbench
================================

Name: irq_sequencer

Overview:
- Interrupt controller for the 16-bit CPU.
- Latches rising edges on external interrupt lines and arbitrates them by fixed priority, gated by per-line enables and the global mask flag (f_bus[2]).
- Handshakes with the control unit at instruction boundaries, then sequences the flags register: push, then mask, then vector delivery, then restore on return-from-interrupt.
- Sits beside the comparator/flags register and drives its push, mask_int and load strobes.

Parameters:
N_IRQ, 4, number of interrupt request lines (1..8)
VEC_BASE, 16'h0010, vector address of line 0
VEC_STRIDE, 16'h0004, address spacing between consecutive line vectors

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
irq  input  N_IRQ  interrupt request lines, already synchronous to clk
en_we  input  1  write strobe for enable register
en_wdata  input  N_IRQ  new enable mask
f_bus  input  3  flags from flags register; bit 2 = interrupt mask
cpu_boundary  input  1  control unit is at an instruction boundary this cycle
int_ack  input  1  control unit accepts interrupt entry
reti  input  1  return-from-interrupt executed
int_req  output  1  interrupt entry requested
flag_push  output  1  strobe: flags register drives bus1 for stacking
flag_mask  output  1  strobe: set interrupt mask bit
flag_load  output  1  strobe: flags register reloads from bus1 (restore)
vec_valid  output  1  vec_out holds the handler address
vec_out  output  16  handler address
active_id  output  3  id of the granted line (zero-extended)
busy  output  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; pending=0, irq_q=0, en=0, grant id=0. All outputs 0, vec_out=0. Reset mid-sequence aborts immediately; no strobe completes.
- Edge detect: irq_q <= irq each cycle. rise[i] = irq[i] & ~irq_q[i] sets pending[i] regardless of en. A held level does not re-pend.
- en_we: en <= en_wdata in any state.
- eligible = pending & en. Winner is the lowest-index set bit (line 0 has highest priority).
- All outputs are decoded from the state register (Moore). Strobes are high for exactly one cycle per visit.
- FSM:
  - IDLE: if eligible != 0 and f_bus[2]==0 and cpu_boundary, latch winner id and go to REQ.
  - REQ: int_req=1.
    - int_ack=1 -> PUSH.
    - Else if f_bus[2]==1 -> IDLE (request withdrawn; pending bit kept).
    - Else stay. No re-arbitration while in REQ.
  - PUSH: flag_push=1 -> MASK.
  - MASK: flag_mask=1 -> VECTOR.
  - VECTOR: vec_valid=1; vec_out = VEC_BASE + id*VEC_STRIDE (16-bit, wraps modulo 2^16); clear pending[id] -> SERVICE.
  - SERVICE: wait for reti=1 -> RESTORE. New edges keep latching meanwhile.
  - RESTORE: flag_load=1 -> IDLE.
- Latency: ack to vec_valid is 3 cycles (PUSH, MASK, VECTOR).
- vec_out holds its last value outside VECTOR; only vec_valid qualifies it.
- active_id is valid from REQ through RESTORE and holds its value in IDLE.
- Clearing pending[id] in VECTOR in the same cycle as a new rise on the same line: set wins, pending stays 1.
- int_ack outside REQ and reti outside SERVICE are ignored.
- No nesting: a new interrupt is considered only after returning to IDLE.

Test Plan:
- Reset, en=4'b1111, pulse irq[2], cpu_boundary=1, ack 2 cycles after int_req -> flag_push, flag_mask, vec_valid on consecutive single cycles; vec_out=16'h0018; active_id=2; pending[2] cleared.
- irq[3] and irq[1] rise in the same cycle -> grant id=1, vec_out=16'h0014. After reti and RESTORE (flag_load pulse), line 3 is serviced, vec_out=16'h001C.
- f_bus[2]=1 with irq[0] pending -> int_req stays 0. Clear mask -> int_req rises next boundary cycle. Separate run: set f_bus[2] during REQ before ack -> IDLE, pending[0] still 1.
- en=4'b0000, pulse irq[1] -> no request. Write en=4'b0010 -> request issued (latched edge survives).
- irq[0] held high across the whole service -> exactly one service. New rise in the VECTOR cycle -> pending[0]=1 after, a second service follows.
- rst_n low while in PUSH -> all outputs 0 immediately, pending 0, busy 0. With VEC_BASE=16'hFFFC, id=1 -> vec_out=16'h0000 (wrap).

Source files
------------

// File: rtl/irq_sequencer.sv
// irq_sequencer - interrupt controller for the 16-bit CPU.
//
// Latches rising edges on the request lines and picks the winner by fixed
// priority (line 0 highest). A line must be both pending and enabled to win,
// and the global mask flag (f_bus[2]) must be clear. The handshake with the
// control unit happens at instruction boundaries. After that the controller
// sequences the flags register in this order: push, mask, vector delivery,
// and restore after return-from-interrupt.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   irq          request lines, already synchronous to clk
//   en_we        write strobe for the enable register
//   en_wdata     new enable mask
//   f_bus        flags from the flags register; bit 2 is the interrupt mask
//   cpu_boundary control unit is at an instruction boundary this cycle
//   int_ack      control unit accepts interrupt entry
//   reti         return-from-interrupt executed
//   int_req      interrupt entry requested
//   flag_push    strobe: flags register drives bus1 for stacking
//   flag_mask    strobe: set the interrupt mask bit
//   flag_load    strobe: flags register reloads from bus1
//   vec_valid    vec_out holds the handler address
//   vec_out      handler address
//   active_id    id of the granted line (zero-extended)
//   busy         sequencer is not idle
module irq_sequencer #(
  parameter int          N_IRQ      = 4,
  parameter logic [15:0] VEC_BASE   = 16'h0010,
  parameter logic [15:0] VEC_STRIDE = 16'h0004
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_IRQ-1:0] irq,
  input  logic             en_we,
  input  logic [N_IRQ-1:0] en_wdata,
  input  logic [2:0]       f_bus,
  input  logic             cpu_boundary,
  input  logic             int_ack,
  input  logic             reti,
  output logic             int_req,
  output logic             flag_push,
  output logic             flag_mask,
  output logic             flag_load,
  output logic             vec_valid,
  output logic [15:0]      vec_out,
  output logic [2:0]       active_id,
  output logic             busy
);

  typedef enum logic [2:0] {
    IDLE, REQ, PUSH, MASK, VECTOR, SERVICE, RESTORE
  } state_t;

  state_t state, state_next;

  logic [N_IRQ-1:0] irq_q, pending, en;
  logic [N_IRQ-1:0] rise, eligible, clear;
  logic [2:0]       id, winner;
  logic [15:0]      vec, vec_calc;
  logic             masked;

  // Only the interrupt mask bit of the flags is used here.
  logic unused_flags;
  assign unused_flags = ^f_bus[1:0];

  assign masked   = f_bus[2];
  assign rise     = irq & ~irq_q;
  assign eligible = pending & en;
  assign vec_calc = VEC_BASE + 16'(id) * VEC_STRIDE;  // wraps modulo 2^16

  // Lowest-index eligible line wins. The loop descends so the last match
  // found is the lowest index.
  always_comb begin
    winner = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  // One-hot clear of the serviced line, asserted only in VECTOR.
  always_comb begin
    clear = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clear[i] = (state == VECTOR) && (id == 3'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      irq_q   <= '0;
      pending <= '0;
      en      <= '0;
      id      <= 3'd0;
      vec     <= 16'h0000;
    end else begin
      state   <= state_next;
      irq_q   <= irq;
      // A new rise in the same cycle as the clear wins, so that edge is kept.
      pending <= (pending & ~clear) | rise;
      if (en_we) en <= en_wdata;
      if (state == IDLE && state_next == REQ) id <= winner;
      // Load the vector one cycle early so vec_out is a plain register during
      // VECTOR. It keeps that value afterwards.
      if (state == MASK) vec <= vec_calc;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (eligible != '0 && !masked && cpu_boundary) state_next = REQ;
      REQ: begin
        if (int_ack)     state_next = PUSH;
        else if (masked) state_next = IDLE;  // withdrawn; pending bit kept
      end
      PUSH:    state_next = MASK;
      MASK:    state_next = VECTOR;
      VECTOR:  state_next = SERVICE;
      SERVICE: if (reti) state_next = RESTORE;
      RESTORE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Moore outputs, decoded from the state register only.
  always_comb begin
    int_req   = (state == REQ);
    flag_push = (state == PUSH);
    flag_mask = (state == MASK);
    vec_valid = (state == VECTOR);
    flag_load = (state == RESTORE);
    busy      = (state != IDLE);
    vec_out   = vec;
    active_id = id;
  end

endmodule

// File: tb/tb_irq_sequencer.sv
// Directed testbench for irq_sequencer. Two instances share all inputs:
// the default vector base, and VEC_BASE=16'hFFFC to check the address wrap.
module tb_irq_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  irq;
  logic        en_we;
  logic [3:0]  en_wdata;
  logic [2:0]  f_bus;
  logic        cpu_boundary, int_ack, reti;

  logic        int_req, flag_push, flag_mask, flag_load, vec_valid, busy;
  logic [15:0] vec_out;
  logic [2:0]  active_id;

  logic        int_req2, flag_push2, flag_mask2, flag_load2, vec_valid2, busy2;
  logic [15:0] vec_out2;
  logic [2:0]  active_id2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  irq_sequencer #(.N_IRQ(4), .VEC_BASE(16'h0010), .VEC_STRIDE(16'h0004)) dut (
    .clk(clk), .rst_n(rst_n), .irq(irq), .en_we(en_we), .en_wdata(en_wdata),
    .f_bus(f_bus), .cpu_boundary(cpu_boundary), .int_ack(int_ack), .reti(reti),
    .int_req(int_req), .flag_push(flag_push), .flag_mask(flag_mask),
    .flag_load(flag_load), .vec_valid(vec_valid), .vec_out(vec_out),
    .active_id(active_id), .busy(busy)
  );

  irq_sequencer #(.N_IRQ(4), .VEC_BASE(16'hFFFC), .VEC_STRIDE(16'h0004)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .irq(irq), .en_we(en_we), .en_wdata(en_wdata),
    .f_bus(f_bus), .cpu_boundary(cpu_boundary), .int_ack(int_ack), .reti(reti),
    .int_req(int_req2), .flag_push(flag_push2), .flag_mask(flag_mask2),
    .flag_load(flag_load2), .vec_valid(vec_valid2), .vec_out(vec_out2),
    .active_id(active_id2), .busy(busy2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the bench drives and samples 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Starts in REQ. Acks at once, then walks the entry/return sequence.
  task automatic do_service(input logic [2:0] exp_id, input logic [15:0] exp_vec,
                            input logic [15:0] exp_vec2);
    chk("svc_req", {31'd0, int_req}, 32'd1);
    chk("svc_id", {29'd0, active_id}, {29'd0, exp_id});
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("svc_push", {31'd0, flag_push}, 32'd1);
    chk("svc_push_req_low", {31'd0, int_req}, 32'd0);
    step();
    chk("svc_mask", {30'd0, flag_mask, flag_push}, 32'd2);
    step();
    chk("svc_vvalid", {30'd0, vec_valid, flag_mask}, 32'd2);
    chk("svc_vec", {16'd0, vec_out}, {16'd0, exp_vec});
    chk("svc_vec_wrap", {16'd0, vec_out2}, {16'd0, exp_vec2});
    step();
    chk("svc_service", {30'd0, vec_valid, busy}, 32'd1);
    chk("svc_vec_hold", {16'd0, vec_out}, {16'd0, exp_vec});
    chk("svc_pend_clr", {31'd0, dut.pending[exp_id]}, 32'd0);
    reti = 1'b1; step(); reti = 1'b0;
    chk("svc_load", {31'd0, flag_load}, 32'd1);
    step();
    chk("svc_idle", {30'd0, busy, flag_load}, 32'd0);
    chk("svc_id_hold", {29'd0, active_id}, {29'd0, exp_id});
    $display("service id=%0d vec=%04h wrapvec=%04h done", exp_id, vec_out, vec_out2);
  endtask

  initial begin
    rst_n = 1'b0; irq = 4'h0; en_we = 1'b0; en_wdata = 4'h0; f_bus = 3'b000;
    cpu_boundary = 1'b1; int_ack = 1'b0; reti = 1'b0;
    #12;
    chk("rst_outputs", {int_req, flag_push, flag_mask, flag_load, vec_valid, busy,
                        active_id, vec_out}, 32'd0);
    rst_n = 1'b1;
    step();
    en_we = 1'b1; en_wdata = 4'b1111; step(); en_we = 1'b0;

    // Single line 2: ack arrives two cycles after int_req.
    irq = 4'b0100; step(); irq = 4'b0000;
    chk("t1_pending2", {31'd0, dut.pending[2]}, 32'd1);
    step();
    chk("t1_req", {31'd0, int_req}, 32'd1);
    step();
    do_service(3'd2, 16'h0018, 16'h0004);

    // Lines 3 and 1 together: 1 wins, 3 follows.
    irq = 4'b1010; step(); irq = 4'b0000; step();
    do_service(3'd1, 16'h0014, 16'h0000);
    step();
    do_service(3'd3, 16'h001C, 16'h0008);

    // Mask set: no request. Clear the mask, then the boundary gates it.
    f_bus = 3'b100;
    irq = 4'b0001; step(); irq = 4'b0000; step(); step();
    chk("t3_masked", {30'd0, int_req, busy}, 32'd0);
    f_bus = 3'b000; cpu_boundary = 1'b0; step();
    chk("t3_no_boundary", {31'd0, int_req}, 32'd0);
    cpu_boundary = 1'b1; step();
    chk("t3_req", {31'd0, int_req}, 32'd1);
    f_bus = 3'b100; step();
    chk("t3_withdrawn", {30'd0, int_req, busy}, 32'd0);
    chk("t3_pending_kept", {31'd0, dut.pending[0]}, 32'd1);
    f_bus = 3'b000; step();
    do_service(3'd0, 16'h0010, 16'hFFFC);

    // Disabled line: the edge is latched and serviced once it is enabled.
    en_we = 1'b1; en_wdata = 4'b0000; step(); en_we = 1'b0;
    irq = 4'b0010; step(); irq = 4'b0000; step(); step();
    chk("t4_disabled", {31'd0, int_req}, 32'd0);
    en_we = 1'b1; en_wdata = 4'b0010; step(); en_we = 1'b0;
    step();
    do_service(3'd1, 16'h0014, 16'h0000);
    en_we = 1'b1; en_wdata = 4'b1111; step(); en_we = 1'b0;

    // Line 0 held high for the whole service: it is serviced exactly once.
    irq = 4'b0001; step(); step();
    do_service(3'd0, 16'h0010, 16'hFFFC);
    step(); step();
    chk("t5_held_once", {30'd0, int_req, busy}, 32'd0);
    irq = 4'b0000; step();

    // A new rise in the VECTOR cycle keeps pending[0] set.
    irq = 4'b0001; step(); irq = 4'b0000; step();
    int_ack = 1'b1; step(); int_ack = 1'b0; step(); step();
    chk("t5_vector", {31'd0, vec_valid}, 32'd1);
    irq = 4'b0001; step(); irq = 4'b0000;
    chk("t5_set_wins", {31'd0, dut.pending[0]}, 32'd1);
    reti = 1'b1; step(); reti = 1'b0; step(); step();
    do_service(3'd0, 16'h0010, 16'hFFFC);

    // Reset asserted while in PUSH.
    irq = 4'b0100; step(); irq = 4'b0000; step();
    int_ack = 1'b1; step(); int_ack = 1'b0;
    chk("t6_in_push", {31'd0, flag_push}, 32'd1);
    #2 rst_n = 1'b0; #1;
    chk("t6_rst_outputs", {int_req, flag_push, flag_mask, flag_load, vec_valid, busy,
                           active_id, vec_out}, 32'd0);
    chk("t6_rst_pending", {28'd0, dut.pending}, 32'd0);
    step(); rst_n = 1'b1; step();
    chk("t6_after_rst", {30'd0, flag_mask, busy}, 32'd0);
    irq = 4'b0001; step(); irq = 4'b0000; step(); step();
    chk("t6_en_cleared", {31'd0, int_req}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Backstop so the run always ends on its own.
  initial begin
    #100000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
